// File: rtl/jug_fault_confirm.sv
// Debounces the per-channel judge flag into a confirmed fault status, with an
// optional latched mode released only through a host clear-request handshake.
module jug_fault_confirm #(
  parameter int CNT_W   = 8,
  parameter int SET_CNT = 8,
  parameter int CLR_CNT = 16,
  parameter int EVT_W   = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             chn_dgd_en,
  input  logic             smp_vld,
  input  logic             jug_result,
  input  logic             flt_latch_en,
  input  logic             flt_clr_req,
  output logic             flt_state,
  output logic             flt_pend,
  output logic             flt_rise,
  output logic             flt_fall,
  output logic             flt_clr_ack,
  output logic [EVT_W-1:0] flt_evt_cnt
);

  typedef enum logic [1:0] {
    ST_NORM     = 2'd0,
    ST_PEND_SET = 2'd1,
    ST_FAULT    = 2'd2,
    ST_PEND_CLR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SET_LIM = CNT_W'(SET_CNT);
  localparam logic [CNT_W-1:0] CLR_LIM = CNT_W'(CLR_CNT);
  localparam logic             SET_ONE = (SET_CNT == 1);
  localparam logic             CLR_ONE = (CLR_CNT == 1);

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt, cnt_inc;
  logic             rise_nxt, fall_nxt, ack_nxt, acked_nxt;
  logic             flt_state_r, flt_pend_r, rise_r, fall_r, ack_r, acked_r;
  logic [EVT_W-1:0] evt_r;

  assign cnt_inc = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, debounce counter and pulse decisions
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    if (!chn_dgd_en) begin
      state_nxt = ST_NORM;
      cnt_nxt   = '0;
      ack_nxt   = flt_clr_req & ~acked_r;
    end else begin
      case (state_r)
        ST_NORM: begin
          if (smp_vld && jug_result) begin
            if (SET_ONE) begin
              state_nxt = ST_FAULT;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = ST_PEND_SET;
              cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt = ST_NORM;
          end
        end
        ST_PEND_SET: begin
          if (smp_vld && jug_result) begin
            if (cnt_inc == SET_LIM) begin
              state_nxt = ST_FAULT;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else if (smp_vld) begin
            state_nxt = ST_NORM;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_PEND_SET;
          end
        end
        ST_FAULT: begin
          // Latched faults only start clearing on a sample that carries a clear request
          if (smp_vld && !jug_result && (!flt_latch_en || flt_clr_req)) begin
            if (CLR_ONE) begin
              state_nxt = ST_NORM;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = ST_PEND_CLR;
              cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt = ST_FAULT;
          end
        end
        ST_PEND_CLR: begin
          if (smp_vld && !jug_result) begin
            if (cnt_inc == CLR_LIM) begin
              state_nxt = ST_NORM;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else if (smp_vld) begin
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_PEND_CLR;
          end
        end
        default: begin
          state_nxt = ST_NORM;
          cnt_nxt   = '0;
        end
      endcase
      ack_nxt = flt_clr_req & ~acked_r &
                ((state_r == ST_NORM) | (state_r == ST_PEND_SET) | fall_nxt);
    end
    acked_nxt = flt_clr_req & (acked_r | ack_nxt);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_r     <= ST_NORM;
      cnt_r       <= '0;
      flt_state_r <= 1'b0;
      flt_pend_r  <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      ack_r       <= 1'b0;
      acked_r     <= 1'b0;
      evt_r       <= '0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      flt_state_r <= (state_nxt == ST_FAULT) || (state_nxt == ST_PEND_CLR);
      flt_pend_r  <= (state_nxt == ST_PEND_SET) || (state_nxt == ST_PEND_CLR);
      rise_r      <= rise_nxt;
      fall_r      <= fall_nxt;
      ack_r       <= ack_nxt;
      acked_r     <= acked_nxt;
      if (rise_nxt && (evt_r != {EVT_W{1'b1}})) begin
        evt_r <= evt_r + {{(EVT_W-1){1'b0}}, 1'b1};
      end else begin
        evt_r <= evt_r;
      end
    end
  end

  assign flt_state   = flt_state_r;
  assign flt_pend    = flt_pend_r;
  assign flt_rise    = rise_r;
  assign flt_fall    = fall_r;
  assign flt_clr_ack = ack_r;
  assign flt_evt_cnt = evt_r;

endmodule
